minmax_window_ctrl: RTL and testbench

MINMAX_WINDOW_CTRL -- requirements
Module: minmax_window_ctrl

---
 rtl/minmax_window_ctrl.sv | 130 +++++++++++++
 tb/tb_minmax_window_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_window_ctrl.sv
// Two-channel windowed min/max tracker: after an optional settle period it
// acquires WIN_CYC samples per channel and reports midpoint and peak-to-peak.
module minmax_window_ctrl #(
    parameter int DW         = 12,
    parameter int SETTLE_CYC = 100_000,
    parameter int WIN_CYC    = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          cont,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    output logic [DW-1:0] mid0,
    output logic [DW-1:0] mid1,
    output logic [DW-1:0] amp0,
    output logic [DW-1:0] amp1,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, SETTLE, ACQ, CALC, HOLD} state_t;

    // Counter is loaded with (length - 1) on entry and the phase ends when it reaches zero.
    localparam logic [29:0] SETTLE_LD = 30'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [29:0] WIN_LD    = 30'(WIN_CYC - 1);

    state_t        state;
    logic [29:0]   cnt;
    logic [DW-1:0] max0, min0, max1, min1;
    logic [DW:0]   sum0, sum1;
    logic          first_smp;

    assign sum0      = {1'b0, max0} + {1'b0, min0};
    assign sum1      = {1'b0, max1} + {1'b0, min1};
    assign first_smp = (cnt == WIN_LD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            max0      <= '0;
            min0      <= '0;
            max1      <= '0;
            min1      <= '0;
            mid0      <= '0;
            mid1      <= '0;
            amp0      <= '0;
            amp1      <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            // Results registers deliberately keep their last values.
            state     <= IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (SETTLE_CYC == 0) begin
                            state <= ACQ;
                            cnt   <= WIN_LD;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LD;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= ACQ;
                        cnt   <= WIN_LD;
                    end else begin
                        cnt <= cnt - 30'd1;
                    end
                end
                ACQ: begin
                    if (first_smp) begin
                        max0 <= data_in0;
                        min0 <= data_in0;
                        max1 <= data_in1;
                        min1 <= data_in1;
                    end else begin
                        if (data_in0 > max0) max0 <= data_in0;
                        if (data_in0 < min0) min0 <= data_in0;
                        if (data_in1 > max1) max1 <= data_in1;
                        if (data_in1 < min1) min1 <= data_in1;
                    end
                    if (cnt == '0) begin
                        state <= CALC;
                    end else begin
                        cnt <= cnt - 30'd1;
                    end
                end
                CALC: begin
                    mid0      <= sum0[DW:1];
                    mid1      <= sum1[DW:1];
                    amp0      <= max0 - min0;
                    amp1      <= max1 - min1;
                    state     <= HOLD;
                    res_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (cont) begin
                            state <= ACQ;
                            cnt   <= WIN_LD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_window_ctrl.sv
// Randomized self-checking bench for minmax_window_ctrl; results are predicted
// from the raw window samples and the nominal phase lengths.
module tb_minmax_window_ctrl;

    localparam int DW     = 12;
    localparam int SETTLE = 4;
    localparam int WIN    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, cont = 1'b0, res_ready = 1'b0;
    logic          start_z = 1'b0, abort_z = 1'b0, res_ready_z = 1'b0;
    logic [DW-1:0] data_in0 = '0, data_in1 = '0;
    logic [DW-1:0] mid0, mid1, amp0, amp1, mid0_z, mid1_z, amp0_z, amp1_z;
    logic          res_valid, busy, res_valid_z, busy_z;

    logic [DW-1:0] o_mid0[2], o_mid1[2], o_amp0[2], o_amp1[2];
    logic          o_rv[2], o_busy[2];

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] w0[WIN], w1[WIN];
    int            exp_mid0 = 0, exp_amp0 = 0, exp_mid1 = 0, exp_amp1 = 0;
    int            lat;

    minmax_window_ctrl #(.DW(DW), .SETTLE_CYC(SETTLE), .WIN_CYC(WIN)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
        .data_in0(data_in0), .data_in1(data_in1),
        .mid0(mid0), .mid1(mid1), .amp0(amp0), .amp1(amp1),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
    );

    minmax_window_ctrl #(.DW(DW), .SETTLE_CYC(0), .WIN_CYC(WIN)) dut_z (
        .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .cont(cont),
        .data_in0(data_in0), .data_in1(data_in1),
        .mid0(mid0_z), .mid1(mid1_z), .amp0(amp0_z), .amp1(amp1_z),
        .res_valid(res_valid_z), .res_ready(res_ready_z), .busy(busy_z)
    );

    assign o_mid0[0] = mid0;      assign o_mid0[1] = mid0_z;
    assign o_mid1[0] = mid1;      assign o_mid1[1] = mid1_z;
    assign o_amp0[0] = amp0;      assign o_amp0[1] = amp0_z;
    assign o_amp1[0] = amp1;      assign o_amp1[1] = amp1_z;
    assign o_rv[0]   = res_valid; assign o_rv[1]   = res_valid_z;
    assign o_busy[0] = busy;      assign o_busy[1] = busy_z;

    always #5 clk = ~clk;

    initial begin
        #200_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic randomize_data();
        data_in0 = DW'($urandom);
        data_in1 = DW'($urandom);
    endtask

    // mode 0: full-range, mode 1: narrow cluster, mode 2: ramp / constant, mode 3: alternating extremes
    task automatic fill_window(input int mode);
        for (int i = 0; i < WIN; i++) begin
            case (mode)
                1:       begin w0[i] = DW'(12'h800 + $urandom_range(0, 15)); w1[i] = DW'($urandom_range(0, 3)); end
                2:       begin w0[i] = DW'(100 + i); w1[i] = 12'hFFF; end
                3:       begin w0[i] = (i % 2 == 1) ? 12'hFFF : 12'h000; w1[i] = DW'($urandom); end
                default: begin w0[i] = DW'($urandom); w1[i] = DW'($urandom); end
            endcase
        end
    endtask

    task automatic model();
        int mx0, mn0, mx1, mn1;
        mx0 = 0; mn0 = 4095; mx1 = 0; mn1 = 4095;
        for (int i = 0; i < WIN; i++) begin
            if (int'(w0[i]) > mx0) mx0 = int'(w0[i]);
            if (int'(w0[i]) < mn0) mn0 = int'(w0[i]);
            if (int'(w1[i]) > mx1) mx1 = int'(w1[i]);
            if (int'(w1[i]) < mn1) mn1 = int'(w1[i]);
        end
        exp_mid0 = (mx0 + mn0) / 2;
        exp_amp0 = mx0 - mn0;
        exp_mid1 = (mx1 + mn1) / 2;
        exp_amp1 = mx1 - mn1;
    endtask

    task automatic check_results(input bit sel, input string tag);
        checkOutput({tag, "_valid"}, o_rv[sel], 1);
        checkOutput({tag, "_mid0"}, o_mid0[sel], exp_mid0);
        checkOutput({tag, "_amp0"}, o_amp0[sel], exp_amp0);
        checkOutput({tag, "_mid1"}, o_mid1[sel], exp_mid1);
        checkOutput({tag, "_amp1"}, o_amp1[sel], exp_amp1);
    endtask

    // Called right after the edge that leaves IDLE (or the continuous handshake edge).
    task automatic applyStimulus(input bit sel, input int settle, input bit start_in_acq, output int latency);
        int n;
        latency = 1;
        for (int i = 0; i < settle; i++) begin
            randomize_data();
            checkOutput("settle_busy", o_busy[sel], 1);
            tick();
            latency++;
        end
        for (int i = 0; i < WIN; i++) begin
            data_in0 = w0[i];
            data_in1 = w1[i];
            cont = 1'($urandom);
            if (!sel) res_ready = 1'($urandom);
            if (start_in_acq && i == 2) start = 1'b1;
            tick();
            start = 1'b0;
            latency++;
        end
        res_ready = 1'b0;
        cont = 1'b0;
        randomize_data();
        n = 0;
        while (!o_rv[sel] && n < 10) begin
            tick();
            latency++;
            n++;
        end
    endtask

    task automatic hold_cycles(input bit sel, input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            randomize_data();
            cont = 1'($urandom);
            if (!sel) start = 1'($urandom);
            tick();
            start = 1'b0;
            check_results(sel, tag);
        end
        cont = 1'b0;
    endtask

    task automatic handshake(input bit sel, input bit c);
        cont = c;
        if (sel) res_ready_z = 1'b1;
        else     res_ready = 1'b1;
        randomize_data();
        tick();
        res_ready = 1'b0;
        res_ready_z = 1'b0;
        cont = 1'b0;
        checkOutput("hs_valid", o_rv[sel], 0);
        checkOutput("hs_busy", o_busy[sel], c);
    endtask

    task automatic start_main();
        start = 1'b1;
        randomize_data();
        tick();
        start = 1'b0;
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            checkOutput("rst_mid0", o_mid0[s], 0);
            checkOutput("rst_amp0", o_amp0[s], 0);
            checkOutput("rst_mid1", o_mid1[s], 0);
            checkOutput("rst_amp1", o_amp1[s], 0);
            checkOutput("rst_valid", o_rv[s], 0);
            checkOutput("rst_busy", o_busy[s], 0);
        end
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", busy, 0);

        // Ramp channel 0, constant full-scale channel 1
        fill_window(2);
        start_main();
        applyStimulus(0, SETTLE, 0, lat);
        checkOutput("ramp_latency", lat, SETTLE + WIN + 2);
        model();
        check_results(0, "ramp");
        checkOutput("ramp_mid0_abs", mid0, 103);
        checkOutput("ramp_amp0_abs", amp0, 7);

        // Consumer stalls for 20 cycles, then accepts and block returns idle
        hold_cycles(0, 20, "stall");
        handshake(0, 0);
        tick();
        checkOutput("post_hs_valid", res_valid, 0);
        checkOutput("post_hs_busy", busy, 0);

        // Abort wins over a simultaneous start
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_vs_start_busy", busy, 0);

        // Random windows: settle pass, continuous follow-up, then back to idle
        for (int it = 0; it < 6; it++) begin
            fill_window(it % 2);
            start_main();
            applyStimulus(0, SETTLE, it == 0, lat);
            checkOutput("rnd_latency", lat, SETTLE + WIN + 2);
            model();
            check_results(0, "rnd");
            hold_cycles(0, $urandom_range(0, 4), "rnd_hold");
            fill_window($urandom_range(0, 1));
            handshake(0, 1);
            applyStimulus(0, 0, 0, lat);
            checkOutput("rnd_cont_latency", lat, WIN + 2);
            model();
            check_results(0, "rnd_cont");
            hold_cycles(0, $urandom_range(0, 3), "rnd_cont_hold");
            handshake(0, 0);
        end

        // Continuous re-entry with alternating extremes on channel 0
        fill_window(0);
        start_main();
        applyStimulus(0, SETTLE, 1, lat);
        checkOutput("alt_first_latency", lat, SETTLE + WIN + 2);
        model();
        check_results(0, "alt_first");
        fill_window(3);
        handshake(0, 1);
        applyStimulus(0, 0, 0, lat);
        checkOutput("alt_latency", lat, WIN + 2);
        model();
        check_results(0, "alt");
        checkOutput("alt_mid0_abs", mid0, 2047);
        checkOutput("alt_amp0_abs", amp0, 4095);
        handshake(0, 0);

        // Abort in the fourth ACQ cycle: results never appear, old values stay
        start_main();
        for (int i = 0; i < SETTLE + 3; i++) begin
            randomize_data();
            tick();
        end
        abort = 1'b1;
        randomize_data();
        tick();
        abort = 1'b0;
        checkOutput("abort_acq_busy", busy, 0);
        checkOutput("abort_acq_valid", res_valid, 0);
        checkOutput("abort_acq_mid0", mid0, exp_mid0);
        checkOutput("abort_acq_amp0", amp0, exp_amp0);
        checkOutput("abort_acq_mid1", mid1, exp_mid1);
        checkOutput("abort_acq_amp1", amp1, exp_amp1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            randomize_data();
            tick();
            if (res_valid || busy) seen = 1;
        end
        checkOutput("abort_stays_idle", seen, 0);

        // Abort in HOLD beats a simultaneous continuous handshake
        fill_window(0);
        start_main();
        applyStimulus(0, SETTLE, 0, lat);
        model();
        check_results(0, "pre_abort_hold");
        abort = 1'b1;
        res_ready = 1'b1;
        cont = 1'b1;
        tick();
        abort = 1'b0;
        res_ready = 1'b0;
        cont = 1'b0;
        checkOutput("abort_hold_valid", res_valid, 0);
        checkOutput("abort_hold_busy", busy, 0);
        checkOutput("abort_hold_mid0", mid0, exp_mid0);
        checkOutput("abort_hold_amp1", amp1, exp_amp1);

        // Asynchronous reset in the middle of SETTLE
        start_main();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_mid0", mid0, 0);
        checkOutput("arst_amp0", amp0, 0);
        checkOutput("arst_mid1", mid1, 0);
        checkOutput("arst_amp1", amp1, 0);
        checkOutput("arst_valid", res_valid, 0);
        checkOutput("arst_busy", busy, 0);
        #3;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < SETTLE + WIN + 4; i++) begin
            randomize_data();
            tick();
            if (res_valid || busy) seen = 1;
        end
        checkOutput("arst_release_idle", seen, 0);

        // Zero-settle build goes straight to acquisition
        fill_window(0);
        start_z = 1'b1;
        randomize_data();
        tick();
        start_z = 1'b0;
        applyStimulus(1, 0, 0, lat);
        checkOutput("z_latency", lat, WIN + 2);
        model();
        check_results(1, "z");
        handshake(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
